// File: rtl/interface_tag_ctx.sv
//==============================================================================
// Module      : interface_tag_ctx
// Description : Tag allocator with per-tag stream context and a registered
//               response path that recycles tags on response delivery.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module interface_tag_ctx #(
  parameter int addr_width = 64,
  parameter int data_width = 1024,
  parameter int nstrms     = 64,
  parameter int tag        = 256,
  parameter int l2_ncl     = 256,
  parameter int max_out    = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_req_v,
  output logic                                  i_req_r,
  input  logic [$clog2(nstrms)-1:0]             i_req_sid,
  input  logic [addr_width-1:0]                 i_req_ea,
  output logic                                  o_req_v,
  input  logic                                  o_req_r,
  output logic [addr_width-1:0]                 o_req_ea,
  output logic [$clog2(tag)-1:0]                o_req_tag,
  input  logic                                  i_rsp_v,
  output logic                                  i_rsp_r,
  input  logic [$clog2(tag)-1:0]                i_rsp_tag,
  input  logic [data_width-1:0]                 i_rsp_data,
  output logic                                  o_rsp_v,
  input  logic                                  o_rsp_r,
  output logic [data_width-1:0]                 o_rsp_data,
  output logic [$clog2(nstrms)-1:0]             o_rsp_sid,
  output logic [$clog2(l2_ncl)-1:0]             o_rsp_ptr,
  output logic                                  o_init_done,
  output logic [$clog2(tag+1)-1:0]              o_free_cnt,
  output logic                                  o_err
);

  localparam int nstrms_width = $clog2(nstrms);
  localparam int tag_width    = $clog2(tag);
  localparam int l2_ncl_width = $clog2(l2_ncl);
  localparam int cnt_width    = $clog2(tag+1);
  localparam int cl_off       = $clog2(data_width/8);
  localparam int scnt_width   = $clog2(max_out+1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]               r_state;
  logic [tag_width-1:0]     r_init_cnt;
  logic [tag_width-1:0]     r_rd_ptr;
  logic [tag_width-1:0]     r_wr_ptr;
  logic [cnt_width-1:0]     r_free_cnt;
  logic [tag_width-1:0]     r_fl [tag];
  logic [tag-1:0]           r_out;
  logic [scnt_width-1:0]    r_scnt [nstrms];
  logic [nstrms_width-1:0]  r_ctx_sid [tag];
  logic [l2_ncl_width-1:0]  r_ctx_ptr [tag];
  logic                     r_rsp_v;
  logic [data_width-1:0]    r_rsp_data;
  logic [nstrms_width-1:0]  r_rsp_sid;
  logic [l2_ncl_width-1:0]  r_rsp_ptr;
  logic [tag_width-1:0]     r_rsp_tag;
  logic                     r_err;

  logic                     w_run;
  logic                     w_can_issue;
  logic                     w_req_xfer;
  logic                     w_rsp_out_xfer;
  logic                     w_rsp_acc;
  logic                     w_rsp_ok;
  logic                     w_rsp_load;
  logic                     w_rsp_bad;
  logic                     w_fl_push;
  logic [tag_width-1:0]     w_fl_push_tag;

  assign w_run       = (r_state == ST_RUN);
  assign w_can_issue = w_run && (r_free_cnt != '0)
                       && (r_scnt[i_req_sid] < scnt_width'(max_out));

  assign o_req_v     = i_req_v & w_can_issue;
  assign i_req_r     = o_req_r & w_can_issue;
  assign o_req_ea    = i_req_ea;
  assign o_req_tag   = r_fl[r_rd_ptr];
  assign w_req_xfer  = i_req_v & i_req_r;

  assign w_rsp_out_xfer = r_rsp_v & o_rsp_r;
  assign i_rsp_r        = w_run & (~r_rsp_v | o_rsp_r);
  assign w_rsp_acc      = i_rsp_v & i_rsp_r;
  // A tag leaving the output register this cycle is no longer outstanding.
  assign w_rsp_ok       = r_out[i_rsp_tag]
                          & ~(w_rsp_out_xfer && (r_rsp_tag == i_rsp_tag));
  assign w_rsp_load     = w_rsp_acc & w_rsp_ok;
  assign w_rsp_bad      = w_rsp_acc & ~w_rsp_ok;

  assign w_fl_push      = ~w_run | w_rsp_out_xfer;
  assign w_fl_push_tag  = w_run ? r_rsp_tag : r_init_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + tag_width'(1);
      if (r_init_cnt == tag_width'(tag-1)) begin
        r_state <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_free_cnt <= '0;
    end else begin
      if (w_fl_push) begin
        r_wr_ptr <= r_wr_ptr + tag_width'(1);
      end
      if (w_req_xfer) begin
        r_rd_ptr <= r_rd_ptr + tag_width'(1);
      end
      r_free_cnt <= r_free_cnt + cnt_width'(w_fl_push) - cnt_width'(w_req_xfer);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_fl_push) begin
      r_fl[r_wr_ptr] <= w_fl_push_tag;
    end
  end

  // Issue and return never touch the same tag in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      if (w_req_xfer) begin
        r_out[o_req_tag] <= 1'b1;
      end
      if (w_rsp_out_xfer) begin
        r_out[r_rsp_tag] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < nstrms; s++) begin
        r_scnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < nstrms; s++) begin
        if ((w_req_xfer && (i_req_sid == nstrms_width'(s)))
            && !(w_rsp_out_xfer && (r_rsp_sid == nstrms_width'(s)))) begin
          r_scnt[s] <= r_scnt[s] + scnt_width'(1);
        end else if (!(w_req_xfer && (i_req_sid == nstrms_width'(s)))
                     && (w_rsp_out_xfer && (r_rsp_sid == nstrms_width'(s)))) begin
          r_scnt[s] <= r_scnt[s] - scnt_width'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_xfer) begin
      r_ctx_sid[o_req_tag] <= i_req_sid;
      r_ctx_ptr[o_req_tag] <= i_req_ea[cl_off +: l2_ncl_width];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_v <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_rsp_load) begin
        r_rsp_v <= 1'b1;
      end else if (w_rsp_out_xfer) begin
        r_rsp_v <= 1'b0;
      end
      if (w_rsp_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rsp_load) begin
      r_rsp_data <= i_rsp_data;
      r_rsp_sid  <= r_ctx_sid[i_rsp_tag];
      r_rsp_ptr  <= r_ctx_ptr[i_rsp_tag];
      r_rsp_tag  <= i_rsp_tag;
    end
  end

  assign o_rsp_v     = r_rsp_v;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_sid   = r_rsp_sid;
  assign o_rsp_ptr   = r_rsp_ptr;
  assign o_init_done = w_run;
  assign o_free_cnt  = r_free_cnt;
  assign o_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_interface_tag_ctx.sv
//==============================================================================
// Module      : tb_interface_tag_ctx
// Description : Scoreboard bench for interface_tag_ctx against a queue-based
//               reference model of tag allocation and return.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_interface_tag_ctx;
  localparam int AW = 64;
  localparam int DW = 1024;
  localparam int NS = 8;
  localparam int NT = 8;
  localparam int NCL = 16;
  localparam int MO = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_req_v, i_req_r, o_req_v, o_req_r;
  logic [2:0]     i_req_sid;
  logic [AW-1:0]  i_req_ea, o_req_ea;
  logic [2:0]     o_req_tag;
  logic           i_rsp_v, i_rsp_r, o_rsp_v, o_rsp_r;
  logic [2:0]     i_rsp_tag;
  logic [DW-1:0]  i_rsp_data, o_rsp_data;
  logic [2:0]     o_rsp_sid;
  logic [3:0]     o_rsp_ptr;
  logic           o_init_done, o_err;
  logic [3:0]     o_free_cnt;

  always #5 clk = ~clk;

  interface_tag_ctx #(
    .addr_width(AW), .data_width(DW), .nstrms(NS),
    .tag(NT), .l2_ncl(NCL), .max_out(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid), .i_req_ea(i_req_ea),
    .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_ea(o_req_ea), .o_req_tag(o_req_tag),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_tag(i_rsp_tag), .i_rsp_data(i_rsp_data),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_data(o_rsp_data),
    .o_rsp_sid(o_rsp_sid), .o_rsp_ptr(o_rsp_ptr),
    .o_init_done(o_init_done), .o_free_cnt(o_free_cnt), .o_err(o_err)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            sid;
    int            ptr;
  } rsp_t;

  int   tag_q[$];
  rsp_t rsp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int   fl[$];
  bit   outst[NT];
  int   cnt[NS];
  int   csid[NT];
  int   cptr[NT];
  bit   pv;
  int   ptag, psid;
  bit   merr;
  int   issued[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (!reset) begin
      if (o_req_v && o_req_r) begin
        if (tag_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL req_unexpected: got tag %0d expected no transfer", o_req_tag);
        end else begin
          chk("req_tag", 64'(o_req_tag), 64'(tag_q.pop_front()));
        end
      end
      if (o_rsp_v && o_rsp_r) begin
        if (rsp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected: got sid %0d expected no transfer", o_rsp_sid);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_sid", 64'(o_rsp_sid), 64'(e.sid));
          chk("rsp_ptr", 64'(o_rsp_ptr), 64'(e.ptr));
          n_tests++;
          if (o_rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL rsp_data: got low %h expected low %h", o_rsp_data[63:0], e.data[63:0]);
          end
        end
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input bit rv, input logic [2:0] sid, input logic [63:0] ea,
                       input bit sv, input logic [2:0] stag, input bit oreqr, input bit orspr);
    bit            can, ireqr, irspr, reqx, rspa, rspo, vld;
    int            t;
    int            idx[$];
    rsp_t          e;
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    i_req_v = rv; i_req_sid = sid; i_req_ea = ea;
    i_rsp_v = sv; i_rsp_tag = stag; i_rsp_data = d;
    o_req_r = oreqr; o_rsp_r = orspr;
    can   = (fl.size() > 0) && (cnt[sid] < MO);
    ireqr = oreqr && can;
    irspr = !pv || orspr;
    reqx  = rv && ireqr;
    rspa  = sv && irspr;
    rspo  = pv && orspr;
    vld   = rspa && outst[stag] && !(rspo && ptag == int'(stag));
    if (reqx) tag_q.push_back(fl[0]);
    if (vld) begin
      e.data = d; e.sid = csid[stag]; e.ptr = cptr[stag];
      rsp_q.push_back(e);
    end
    #1;
    chk("i_req_r", 64'(i_req_r), 64'(ireqr));
    chk("o_req_v", 64'(o_req_v), 64'(rv && can));
    chk("i_rsp_r", 64'(i_rsp_r), 64'(irspr));
    chk("o_rsp_v", 64'(o_rsp_v), 64'(pv));
    chk("free_cnt", 64'(o_free_cnt), 64'(fl.size()));
    chk("err", 64'(o_err), 64'(merr));
    chk("init_done", 64'(o_init_done), 64'd1);
    @(posedge clk); #1;
    if (reqx) begin
      t = fl.pop_front();
      csid[t] = int'(sid);
      cptr[t] = int'((ea >> 7) % NCL);
      outst[t] = 1'b1;
      cnt[sid]++;
      issued.push_back(t);
    end
    if (rspo) begin
      fl.push_back(ptag);
      outst[ptag] = 1'b0;
      cnt[psid]--;
      pv = 1'b0;
    end
    if (vld) begin
      pv = 1'b1; ptag = int'(stag); psid = csid[stag];
      idx = issued.find_first_index(x) with (x == int'(stag));
      if (idx.size() > 0) issued.delete(idx[0]);
    end else if (rspa) begin
      merr = 1'b1;
    end
  endtask

  task automatic do_reset();
    int n;
    reset = 1'b1; i_req_v = 1'b1; o_req_r = 1'b1; i_rsp_v = 1'b0; o_rsp_r = 1'b0;
    @(posedge clk); #1;
    chk("rst_o_rsp_v", 64'(o_rsp_v), 64'd0);
    chk("rst_free_cnt", 64'(o_free_cnt), 64'd0);
    chk("rst_init_done", 64'(o_init_done), 64'd0);
    chk("rst_o_req_v", 64'(o_req_v), 64'd0);
    chk("rst_i_req_r", 64'(i_req_r), 64'd0);
    chk("rst_i_rsp_r", 64'(i_rsp_r), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    reset = 1'b0;
    tag_q.delete(); rsp_q.delete(); issued.delete(); fl.delete();
    for (int i = 0; i < NT; i++) outst[i] = 1'b0;
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    pv = 1'b0; merr = 1'b0;
    #1;
    n = 0;
    while (!o_init_done && n < 40) begin
      chk("init_i_req_r", 64'(i_req_r), 64'd0);
      chk("init_o_req_v", 64'(o_req_v), 64'd0);
      chk("init_i_rsp_r", 64'(i_rsp_r), 64'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("init_cycles", 64'(n), 64'(NT));
    chk("init_free_cnt", 64'(o_free_cnt), 64'(NT));
    for (int i = 0; i < NT; i++) fl.push_back(i);
    i_req_v = 1'b0; o_req_r = 1'b0;
  endtask

  task automatic drain();
    int  g;
    bit  sv;
    g = 0;
    while ((issued.size() > 0 || pv) && g < 200) begin
      sv = issued.size() > 0;
      cycle(1'b0, 3'd0, 64'd0, sv, sv ? 3'(issued[0]) : 3'd0, 1'b0, 1'b1);
      g++;
    end
    chk("drain_done", 64'(issued.size() + int'(pv)), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; i_req_v = 1'b0; i_req_sid = '0; i_req_ea = '0; o_req_r = 1'b0;
    i_rsp_v = 1'b0; i_rsp_tag = '0; i_rsp_data = '0; o_rsp_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset landing in the middle of INIT restarts the fill.
    reset = 1'b1; @(posedge clk); #1;
    reset = 1'b0; repeat (3) @(posedge clk); #1;
    do_reset();

    // Fill all tags in order, then one stalled request.
    for (int i = 0; i < NT; i++)
      cycle(1'b1, 3'(i/2), (i == 3) ? 64'h380 : {$urandom, $urandom}, 1'b0, 3'd0, 1'b1, 1'b1);
    cycle(1'b1, 3'd4, 64'h0, 1'b0, 3'd0, 1'b1, 1'b1);

    // Out-of-order returns, then reissue in return order.
    cycle(1'b0, 3'd0, 64'h0, 1'b1, 3'd3, 1'b0, 1'b1);
    cycle(1'b0, 3'd0, 64'h0, 1'b1, 3'd0, 1'b0, 1'b1);
    cycle(1'b0, 3'd0, 64'h0, 1'b1, 3'd2, 1'b0, 1'b1);
    cycle(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 1'b0, 1'b1);
    cycle(1'b1, 3'd6, {$urandom, $urandom}, 1'b0, 3'd0, 1'b1, 1'b1);
    cycle(1'b1, 3'd6, {$urandom, $urandom}, 1'b0, 3'd0, 1'b1, 1'b1);
    cycle(1'b1, 3'd7, {$urandom, $urandom}, 1'b0, 3'd0, 1'b1, 1'b1);
    drain();

    // Per-stream limit on sid 5.
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 3'd5, {$urandom, $urandom}, 1'b0, 3'd0, 1'b1, 1'b1);
    cycle(1'b1, 3'd5, {$urandom, $urandom}, 1'b1, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 3'd5, {$urandom, $urandom}, 1'b0, 3'd0, 1'b1, 1'b1);
    drain();

    // Randomized traffic with out-of-order returns and backpressure.
    for (int i = 0; i < 600; i++) begin
      bit         rv, sv;
      logic [2:0] sid, stag;
      rv   = ($urandom_range(0, 3) != 0);
      sid  = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'($urandom_range(0, NS-1));
      sv   = (issued.size() > 0) && ($urandom_range(0, 1) == 1);
      stag = sv ? 3'(issued[$urandom_range(0, issued.size()-1)]) : 3'd0;
      cycle(rv, sid, {$urandom, $urandom}, sv, stag,
            $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
    end
    drain();

    // Return of a tag that is not outstanding.
    cycle(1'b0, 3'd0, 64'h0, 1'b1, 3'd4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("err_sticky", 64'(o_err), 64'd1);

    // Reset with tags outstanding and a held response.
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 3'(i), {$urandom, $urandom}, 1'b0, 3'd0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 64'h0, 1'b1, 3'd1, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 64'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    do_reset();

    chk("tag_q_empty", 64'(tag_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/interface_tag_ctx.md
INTERFACE_TAG_CTX -- requirements
Module: interface_tag_ctx

Interface
REQ-001 Parameters, one per line (name, default, meaning) SHALL be:
- addr_width, 64, request effective-address width.
- data_width, 1024, response data width; 128-byte cache line.
- nstrms, 64, stream count.
- tag, 256, tag count; power of two, at least 2.
- l2_ncl, 256, L2 cache lines per stream.
- max_out, 16, per-stream outstanding-tag limit; range 1 to tag.
- Derived widths: nstrms_width, tag_width, l2_ncl_width = $clog2 of each; cnt_width = $clog2(tag+1); cl_off = $clog2(data_width/8).
REQ-002 Ports, one per line (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-high.
- i_req_v, in, 1, request valid.
- i_req_r, out, 1, request ready.
- i_req_sid, in, nstrms_width, stream id.
- i_req_ea, in, addr_width, effective address.
- o_req_v, out, 1, downstream request valid.
- o_req_r, in, 1, downstream request ready.
- o_req_ea, out, addr_width, equals i_req_ea.
- o_req_tag, out, tag_width, tag allocated to the request.
- i_rsp_v, in, 1, response valid.
- i_rsp_r, out, 1, response ready.
- i_rsp_tag, in, tag_width, returned tag.
- i_rsp_data, in, data_width, response data.
- o_rsp_v, out, 1, response valid.
- o_rsp_r, in, 1, response ready.
- o_rsp_data, out, data_width, response data.
- o_rsp_sid, out, nstrms_width, stream id from the context table.
- o_rsp_ptr, out, l2_ncl_width, L2 pointer from the context table.
- o_init_done, out, 1, high in RUN state.
- o_free_cnt, out, cnt_width, number of free tags.
- o_err, out, 1, sticky flag: response carried a tag that was not outstanding.

Function
REQ-003 The block SHALL have two states, INIT and RUN; reset enters INIT.
REQ-004 In INIT, one tag per cycle SHALL be pushed into the free-list FIFO (depth tag), in order 0..tag-1. The push of tag-1 SHALL move the state to RUN, so INIT lasts exactly tag cycles.
REQ-005 During INIT, i_req_r, o_req_v and i_rsp_r SHALL be 0.
REQ-006 can_issue SHALL be: RUN, free list non-empty, and per-stream count[i_req_sid] < max_out.
REQ-007 The request path SHALL be combinational with zero latency:
- o_req_v = i_req_v & can_issue.
- i_req_r = o_req_r & can_issue.
- i_req_r SHALL NOT depend on i_req_v.
REQ-008 o_req_tag SHALL be the free-list head; it is stable while o_req_v is high and o_req_r is low.
REQ-009 On a request transfer (i_req_v & i_req_r), the block SHALL:
- pop the free list;
- write ctx[tag] = {i_req_sid, i_req_ea[cl_off +: l2_ncl_width]};
- set out[tag];
- increment count[sid].
REQ-010 The response path SHALL be a single output register: i_rsp_r = RUN & (~o_rsp_v | o_rsp_r).
REQ-011 A response accepted in cycle N SHALL appear on o_rsp_* in cycle N+1, with o_rsp_sid and o_rsp_ptr read from ctx[i_rsp_tag]. o_rsp_* SHALL hold while o_rsp_v is high and o_rsp_r is low.
REQ-012 On an o_rsp transfer, the block SHALL:
- push the tag back to the free list;
- clear out[tag];
- decrement count[o_rsp_sid].
REQ-013 If an accepted response has out[i_rsp_tag] = 0, the response SHALL be dropped (no o_rsp_v, no free-list push), and o_err SHALL set and stay set until reset.
REQ-014 Simultaneous free-list pop and push SHALL both take effect. o_free_cnt SHALL be unchanged, and a pushed tag SHALL be issuable no earlier than the next cycle.
REQ-015 Simultaneous increment and decrement of the same count[sid] SHALL leave it unchanged. A count SHALL never exceed max_out or go below 0.
REQ-016 Context write and read of the same tag in the same cycle cannot occur, because the tag is not free while outstanding. No bypass is required.
REQ-017 The free list SHALL never overflow: pushes are bounded by outstanding tags.
REQ-018 The block SHALL tolerate out-of-order tag returns.

Reset
REQ-019 reset SHALL be synchronous and active-high. Asserting it in any cycle, including mid-INIT or with tags outstanding, SHALL on the next edge:
- empty the free list;
- clear all out[] bits, count[], o_err and o_rsp_v;
- enter INIT.
REQ-020 Output values during and right after reset SHALL be:
- o_init_done = 0, o_free_cnt = 0;
- o_req_v = 0, i_req_r = 0, i_rsp_r = 0, o_rsp_v = 0, o_err = 0.
- Context table contents are don't-care.

Verification
REQ-021 Release reset with tag=8 -> o_init_done rises after exactly 8 cycles, o_free_cnt=8, and the first issued tag is 0.
REQ-022 Issue 8 requests with tag=8, o_req_r=1 -> tags 0..7 issued in order; after that, i_req_r=0 and o_free_cnt=0.
REQ-023 max_out=2, three back-to-back requests on sid 5 -> the third stalls until the first response for sid 5 transfers on o_rsp, then issues.
REQ-024 Responses returned in order 3,0,2 with ea=0x380 on tag 3 -> each o_rsp appears one cycle after accept; o_rsp_ptr=7 and the correct sid for tag 3; later reissues follow return order.
REQ-025 i_rsp_tag=4 while tag 4 is not outstanding -> no o_rsp_v, o_free_cnt unchanged, o_err=1 until reset.
REQ-026 reset asserted with 3 tags outstanding and o_rsp_r=0 -> o_rsp_v=0 next cycle, INIT repeats, free count returns to tag.
